// File: rtl/mgmt_bus_pkg.sv
// rtl/mgmt_bus_pkg.sv - shared types for the management bus arbiter
package mgmt_bus_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_MAC  = 2'd1,
    OWN_CAM  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OWN,
    RELEASE
  } state_e;

  typedef struct packed {
    logic o;
    logic oe;
  } pad_bus_t;

  localparam int CNT_W = 32;

  localparam pad_bus_t PAD_RELEASED   = '{o: 1'b1, oe: 1'b0};
  localparam pad_bus_t PAD_DRIVE_HIGH = '{o: 1'b1, oe: 1'b1};

  // Ties go to whoever did not own last when round-robin is on, else MAC.
  function automatic owner_e pick_winner(input logic mac, input logic cam,
                                         input owner_e last, input logic rr_en);
    owner_e w;
    if (mac && cam)
      w = (rr_en && last == OWN_MAC) ? OWN_CAM : OWN_MAC;
    else if (mac)
      w = OWN_MAC;
    else if (cam)
      w = OWN_CAM;
    else
      w = OWN_NONE;
    return w;
  endfunction

endpackage

// File: rtl/mgmt_bus_arbiter.sv
// rtl/mgmt_bus_arbiter.sv - grants the shared scl_mdc/sda_mdio pads to MDIO or SCCB master
module mgmt_bus_arbiter
  import mgmt_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned GUARD_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 27000000,
  parameter bit          RR_EN          = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mac_req,
  input  logic       mac_done,
  output logic       mac_gnt,
  input  logic       mac_scl_o,
  input  logic       mac_scl_oe,
  input  logic       mac_sda_o,
  input  logic       mac_sda_oe,
  output logic       mac_sda_i,
  input  logic       cam_req,
  input  logic       cam_done,
  output logic       cam_gnt,
  input  logic       cam_scl_o,
  input  logic       cam_scl_oe,
  input  logic       cam_sda_o,
  input  logic       cam_sda_oe,
  output logic       cam_sda_i,
  output logic       cam_scl_i,
  output logic       pad_scl_o,
  output logic       pad_scl_oe,
  output logic       pad_sda_o,
  output logic       pad_sda_oe,
  input  logic       pad_scl_i,
  input  logic       pad_sda_i,
  output logic [1:0] owner,
  output logic [1:0] timeout_err,
  input  logic       clr_err
);

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  owner_e           winner_q, winner_n;
  owner_e           own_q, own_n;
  owner_e           last_q, last_n;
  logic [1:0]       blk_q, blk_set;
  logic [1:0]       err_q, err_set;
  logic             eff_mac, eff_cam, own_end;
  pad_bus_t         scl_bus, sda_bus;

  // A requester that timed out stays locked out until its req has been seen low.
  assign eff_mac = mac_req & ~blk_q[0];
  assign eff_cam = cam_req & ~blk_q[1];
  assign own_end = (own_q == OWN_MAC) ? (mac_done | ~mac_req) : (cam_done | ~cam_req);

  always_comb begin
    state_n  = state_q;
    cnt_n    = (cnt_q == '0) ? '0 : cnt_q - 32'd1;
    winner_n = winner_q;
    own_n    = own_q;
    last_n   = last_q;
    blk_set  = 2'b00;
    err_set  = 2'b00;
    case (state_q)
      IDLE: begin
        if (eff_mac || eff_cam) begin
          winner_n = pick_winner(eff_mac, eff_cam, last_q, RR_EN);
          last_n   = winner_n;
          cnt_n    = SETUP_CYCLES - 32'd1;
          state_n  = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          own_n   = winner_q;
          cnt_n   = (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_CYCLES - 32'd1;
          state_n = OWN;
        end
      end
      OWN: begin
        if (own_end) begin
          own_n   = OWN_NONE;
          cnt_n   = GUARD_CYCLES - 32'd1;
          state_n = RELEASE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == '0) begin
          err_set = (own_q == OWN_MAC) ? 2'b01 : 2'b10;
          blk_set = err_set;
          own_n   = OWN_NONE;
          cnt_n   = GUARD_CYCLES - 32'd1;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (cnt_q == '0)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      winner_q <= OWN_NONE;
      own_q    <= OWN_NONE;
      last_q   <= OWN_CAM;
      blk_q    <= 2'b00;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      winner_q <= winner_n;
      own_q    <= own_n;
      last_q   <= last_n;
      blk_q    <= (blk_q & {cam_req, mac_req}) | blk_set;
      err_q    <= (err_q & ~{2{clr_err}}) | err_set;
    end
  end

  // Pad mux works off registered state so an async reset releases the pads at once.
  always_comb begin
    scl_bus = PAD_RELEASED;
    sda_bus = PAD_RELEASED;
    case (state_q)
      SETUP: scl_bus = PAD_DRIVE_HIGH;
      OWN: begin
        if (own_q == OWN_MAC) begin
          scl_bus = '{o: mac_scl_o, oe: mac_scl_oe};
          sda_bus = '{o: mac_sda_o, oe: mac_sda_oe};
        end else if (own_q == OWN_CAM) begin
          scl_bus = '{o: cam_scl_o, oe: cam_scl_oe};
          sda_bus = '{o: cam_sda_o, oe: cam_sda_oe};
        end
      end
      default: ;
    endcase
  end

  assign pad_scl_o   = scl_bus.o;
  assign pad_scl_oe  = scl_bus.oe;
  assign pad_sda_o   = sda_bus.o;
  assign pad_sda_oe  = sda_bus.oe;

  assign mac_gnt     = (own_q == OWN_MAC);
  assign cam_gnt     = (own_q == OWN_CAM);
  assign mac_sda_i   = mac_gnt ? pad_sda_i : 1'b1;
  assign cam_sda_i   = cam_gnt ? pad_sda_i : 1'b1;
  assign cam_scl_i   = cam_gnt ? pad_scl_i : 1'b1;
  assign owner       = own_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mgmt_bus_arbiter.sv
// tb/tb_mgmt_bus_arbiter.sv - directed self-checking bench for mgmt_bus_arbiter
module tb_mgmt_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic mac_req, mac_done, mac_scl_o, mac_scl_oe, mac_sda_o, mac_sda_oe;
  logic cam_req, cam_done, cam_scl_o, cam_scl_oe, cam_sda_o, cam_sda_oe;
  logic pad_scl_i, pad_sda_i, clr_err;

  logic       mac_gnt_a, mac_sda_i_a, cam_gnt_a, cam_sda_i_a, cam_scl_i_a;
  logic       pad_scl_o_a, pad_scl_oe_a, pad_sda_o_a, pad_sda_oe_a;
  logic [1:0] owner_a, err_a;
  logic       mac_gnt_b, mac_sda_i_b, cam_gnt_b, cam_sda_i_b, cam_scl_i_b;
  logic       pad_scl_o_b, pad_scl_oe_b, pad_sda_o_b, pad_sda_oe_b;
  logic [1:0] owner_b, err_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;

  always #5 clk = ~clk;

  mgmt_bus_arbiter #(.SETUP_CYCLES(4), .GUARD_CYCLES(16), .TIMEOUT_CYCLES(1000), .RR_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .mac_req(mac_req), .mac_done(mac_done), .mac_gnt(mac_gnt_a),
    .mac_scl_o(mac_scl_o), .mac_scl_oe(mac_scl_oe), .mac_sda_o(mac_sda_o), .mac_sda_oe(mac_sda_oe),
    .mac_sda_i(mac_sda_i_a),
    .cam_req(cam_req), .cam_done(cam_done), .cam_gnt(cam_gnt_a),
    .cam_scl_o(cam_scl_o), .cam_scl_oe(cam_scl_oe), .cam_sda_o(cam_sda_o), .cam_sda_oe(cam_sda_oe),
    .cam_sda_i(cam_sda_i_a), .cam_scl_i(cam_scl_i_a),
    .pad_scl_o(pad_scl_o_a), .pad_scl_oe(pad_scl_oe_a), .pad_sda_o(pad_sda_o_a), .pad_sda_oe(pad_sda_oe_a),
    .pad_scl_i(pad_scl_i), .pad_sda_i(pad_sda_i),
    .owner(owner_a), .timeout_err(err_a), .clr_err(clr_err)
  );

  mgmt_bus_arbiter #(.SETUP_CYCLES(4), .GUARD_CYCLES(16), .TIMEOUT_CYCLES(50), .RR_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .mac_req(mac_req), .mac_done(mac_done), .mac_gnt(mac_gnt_b),
    .mac_scl_o(mac_scl_o), .mac_scl_oe(mac_scl_oe), .mac_sda_o(mac_sda_o), .mac_sda_oe(mac_sda_oe),
    .mac_sda_i(mac_sda_i_b),
    .cam_req(cam_req), .cam_done(cam_done), .cam_gnt(cam_gnt_b),
    .cam_scl_o(cam_scl_o), .cam_scl_oe(cam_scl_oe), .cam_sda_o(cam_sda_o), .cam_sda_oe(cam_sda_oe),
    .cam_sda_i(cam_sda_i_b), .cam_scl_i(cam_scl_i_b),
    .pad_scl_o(pad_scl_o_b), .pad_scl_oe(pad_scl_oe_b), .pad_sda_o(pad_sda_o_b), .pad_sda_oe(pad_sda_oe_b),
    .pad_scl_i(pad_scl_i), .pad_sda_i(pad_sda_i),
    .owner(owner_b), .timeout_err(err_b), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    mac_req = 1'b0; mac_done = 1'b0; cam_req = 1'b0; cam_done = 1'b0; clr_err = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    mac_req = 1'b0; mac_done = 1'b0; mac_scl_o = 1'b1; mac_scl_oe = 1'b0; mac_sda_o = 1'b1; mac_sda_oe = 1'b0;
    cam_req = 1'b0; cam_done = 1'b0; cam_scl_o = 1'b1; cam_scl_oe = 1'b0; cam_sda_o = 1'b1; cam_sda_oe = 1'b0;
    pad_scl_i = 1'b1; pad_sda_i = 1'b1; clr_err = 1'b0;
    tick();
    tick();

    chk("rst_mac_gnt", mac_gnt_a, 0);
    chk("rst_cam_gnt", cam_gnt_a, 0);
    chk("rst_owner", owner_a, 0);
    chk("rst_scl_oe", pad_scl_oe_a, 0);
    chk("rst_sda_oe", pad_sda_oe_a, 0);
    chk("rst_scl_o", pad_scl_o_a, 1);
    chk("rst_sda_o", pad_sda_o_a, 1);
    chk("rst_err", err_a, 0);
    chk("rst_owner_b", owner_b, 0);
    rst_n = 1'b1;

    // Grant latency and pad mux for MAC
    wait_until(10);
    mac_req = 1'b1;
    wait_until(11);
    chk("setup11_scl_oe", pad_scl_oe_a, 1);
    chk("setup11_scl_o", pad_scl_o_a, 1);
    chk("setup11_sda_oe", pad_sda_oe_a, 0);
    chk("setup11_gnt", mac_gnt_a, 0);
    wait_until(14);
    chk("setup14_scl_oe", pad_scl_oe_a, 1);
    chk("setup14_gnt", mac_gnt_a, 0);
    wait_until(15);
    chk("own15_mac_gnt", mac_gnt_a, 1);
    chk("own15_owner", owner_a, 1);
    chk("own15_mac_gnt_b", mac_gnt_b, 1);
    mac_scl_o = 1'b0; mac_scl_oe = 1'b1; mac_sda_o = 1'b0; mac_sda_oe = 1'b1;
    #1;
    chk("own_pad_scl_o", pad_scl_o_a, 0);
    chk("own_pad_sda_oe", pad_sda_oe_a, 1);
    chk("own_pad_sda_o", pad_sda_o_a, 0);
    chk("own_mac_sda_i", mac_sda_i_a, 1);

    // Queued cam request, guard gap after MAC done
    wait_until(50);
    cam_req = 1'b1;
    wait_until(100);
    mac_done = 1'b1;
    mac_req = 1'b0;
    tick();
    mac_done = 1'b0;
    chk("done101_mac_gnt", mac_gnt_a, 0);
    chk("done101_scl_oe", pad_scl_oe_a, 0);
    chk("done101_sda_oe", pad_sda_oe_a, 0);
    wait_until(116);
    chk("guard116_scl_oe", pad_scl_oe_a, 0);
    chk("guard116_cam_gnt", cam_gnt_a, 0);
    wait_until(121);
    chk("setup121_cam_gnt", cam_gnt_a, 0);
    chk("setup121_scl_oe", pad_scl_oe_a, 1);
    wait_until(122);
    chk("own122_cam_gnt", cam_gnt_a, 1);
    chk("own122_owner", owner_a, 2);

    // Input isolation for the non-granted requester
    pad_sda_i = 1'b0;
    pad_scl_i = 1'b0;
    #1;
    chk("iso_cam_sda_i", cam_sda_i_a, 0);
    chk("iso_cam_scl_i", cam_scl_i_a, 0);
    chk("iso_mac_sda_i", mac_sda_i_a, 1);
    pad_sda_i = 1'b1;
    pad_scl_i = 1'b1;
    cam_req = 1'b0;

    // Tie arbitration: dut_a round-robin, dut_b fixed priority
    do_reset();
    t0 = cyc;
    mac_req = 1'b1;
    cam_req = 1'b1;
    wait_until(t0 + 5);
    chk("tie1_a_mac", mac_gnt_a, 1);
    chk("tie1_b_mac", mac_gnt_b, 1);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    wait_until(t0 + 27);
    chk("tie2_a_cam", cam_gnt_a, 1);
    chk("tie2_a_owner", owner_a, 2);
    chk("tie2_b_mac", mac_gnt_b, 1);
    mac_done = 1'b1;
    cam_done = 1'b1;
    tick();
    mac_done = 1'b0;
    cam_done = 1'b0;
    wait_until(t0 + 49);
    chk("tie3_a_mac", mac_gnt_a, 1);
    chk("tie3_b_mac", mac_gnt_b, 1);
    mac_done = 1'b1;
    cam_done = 1'b1;
    tick();
    mac_done = 1'b0;
    cam_done = 1'b0;
    wait_until(t0 + 71);
    chk("tie4_a_cam", cam_gnt_a, 1);
    chk("tie4_b_mac", mac_gnt_b, 1);

    // Hold timeout on dut_b (50 cycles), lockout until req toggles, clr_err
    do_reset();
    t0 = cyc;
    cam_req = 1'b1;
    wait_until(t0 + 54);
    chk("to_last_own_gnt", cam_gnt_b, 1);
    wait_until(t0 + 55);
    chk("to_gnt_drop", cam_gnt_b, 0);
    chk("to_err_b", err_b, 2'b10);
    chk("to_err_a", err_a, 2'b00);
    chk("to_a_still_gnt", cam_gnt_a, 1);
    wait_until(t0 + 80);
    chk("to_lockout_gnt", cam_gnt_b, 0);
    chk("to_lockout_scl_oe", pad_scl_oe_b, 0);
    cam_req = 1'b0;
    tick();
    cam_req = 1'b1;
    wait_until(t0 + 85);
    chk("to_regrant_early", cam_gnt_b, 0);
    wait_until(t0 + 86);
    chk("to_regrant", cam_gnt_b, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err_b", err_b, 2'b00);
    cam_req = 1'b0;

    // Asynchronous reset mid-ownership
    do_reset();
    mac_scl_oe = 1'b1;
    mac_sda_oe = 1'b1;
    t0 = cyc;
    mac_req = 1'b1;
    wait_until(t0 + 7);
    chk("arst_pre_gnt", mac_gnt_a, 1);
    chk("arst_pre_sda_oe", pad_sda_oe_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_scl_oe", pad_scl_oe_a, 0);
    chk("arst_sda_oe", pad_sda_oe_a, 0);
    chk("arst_gnt", mac_gnt_a, 0);
    chk("arst_owner", owner_a, 0);
    tick();
    rst_n = 1'b1;
    t0 = cyc;
    wait_until(t0 + 4);
    chk("arst_regrant_early", mac_gnt_a, 0);
    wait_until(t0 + 5);
    chk("arst_regrant", mac_gnt_a, 1);
    mac_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
